// File: rtl/line_bus_pkg.sv
// -----------------------------------------------------------------------------
// line_bus_pkg
// Shared definitions for the cache-arbiter line protocol responder.
//   resp_state_e      : responder FSM states (also exported on the debug port)
//   READ_BIT          : reqtag bit that marks a read request
//   DEF_LOGLINEOFFSET : default log2 of beats per line
//   BEATS             : beats (words) per line for the default geometry
// -----------------------------------------------------------------------------
package line_bus_pkg;

    localparam int READ_BIT          = 12;
    localparam int DEF_LOGLINEOFFSET = 3;
    localparam int BEATS             = 1 << DEF_LOGLINEOFFSET;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAT_WAIT = 3'd1,
        RD_BEATS = 3'd2,
        WR_BEATS = 3'd3,
        WR_DONE  = 3'd4
    } resp_state_e;

endpackage

// File: rtl/line_store.sv
// -----------------------------------------------------------------------------
// line_store
// Word-addressed backing store for the line responder. Address is
// {line index, word within line}. One write port and one independent read
// port; the read data is registered (valid the cycle after readAddr).
// Contents are never reset.
//   clk        in  clock
//   writeEn    in  write strobe
//   writeAddr  in  word address for the write
//   writeData  in  word to store
//   readAddr   in  word address for the read
//   readData   out registered read word
// -----------------------------------------------------------------------------
module line_store
    import line_bus_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int ADDRW    = 13
) (
    input  logic                clk,
    input  logic                writeEn,
    input  logic [ADDRW-1:0]    writeAddr,
    input  logic [WORDSIZE-1:0] writeData,
    input  logic [ADDRW-1:0]    readAddr,
    output logic [WORDSIZE-1:0] readData
);

    logic [WORDSIZE-1:0] mem [1 << ADDRW];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        readData <= mem[readAddr];
    end

endmodule

// File: rtl/line_fill_responder.sv
// -----------------------------------------------------------------------------
// line_fill_responder
// Memory-side responder for the cache-arbiter line protocol. Accepts
// line-aligned read/write requests, returns reads as a burst of 2^LOGLINEOFFSET
// beats after a fixed latency, and absorbs write bursts into line_store.
//
// Optional build macro: CRITICAL_WORD_FIRST_EN
//   defined   : read beat n returns word[(start + n) mod beats], where start is
//               the word offset of the request address.
//   undefined : read beats always run word 0 .. beats-1.
//
// Ports:
//   clk       in  clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   reqcyc    in  request valid (address phase or write data beat)
//   req       in  byte address (address phase) / write data (write beats)
//   reqtag    in  tag; bit TAGWIDTH-1 = 1 read, 0 write
//   reqack    out acknowledge of an address phase or of a write beat
//   respcyc   out read beat valid
//   resp      out read beat data
//   resptag   out captured request tag
//   respack   in  requester accepts the current read beat
//   writeack  out one-cycle pulse once the last write beat is stored
//   dbgState  out current FSM state
//
// Handshakes: a request transfer (address phase or write beat) completes in
// any cycle where reqcyc and reqack are both high; reqack is a same-cycle
// response to reqcyc and is only given in IDLE or WR_BEATS. A read beat
// transfers in any cycle where respcyc and respack are both high; until then
// resp/resptag are held stable. respack with respcyc low has no effect.
// -----------------------------------------------------------------------------
module line_fill_responder
    import line_bus_pkg::*;
#(
    parameter int WORDSIZE      = 64,
    parameter int LOGLINEOFFSET = $clog2(BEATS),
    parameter int LOGDEPTH      = 10,
    parameter int LATENCY       = 4,
    parameter int TAGWIDTH      = READ_BIT + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reqcyc,
    input  logic [WORDSIZE-1:0] req,
    input  logic [TAGWIDTH-1:0] reqtag,
    output logic                reqack,
    output logic                respcyc,
    output logic [WORDSIZE-1:0] resp,
    output logic [TAGWIDTH-1:0] resptag,
    input  logic                respack,
    output logic                writeack,
    output resp_state_e         dbgState
);

    localparam int ADDRW = LOGDEPTH + LOGLINEOFFSET;
    localparam int LATW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_e                state, stateNxt;
    logic [LOGLINEOFFSET-1:0]   beat, beatNxt;
    logic [LATW-1:0]            cnt, cntNxt;
    logic [LOGDEPTH-1:0]        lineIdx;
    logic [TAGWIDTH-1:0]        tagReg;
    logic                       ackRaw;
    logic                       storeWe;
    logic [LOGLINEOFFSET-1:0]   readWord;
    logic [WORDSIZE-1:0]        readData;

    // Address decode: byte offset bits [2:0] dropped, word bits above them,
    // line index above that; anything higher aliases.
    logic [LOGDEPTH-1:0]        reqIdx;
    assign reqIdx = req[LOGLINEOFFSET+3 +: LOGDEPTH];

`ifdef CRITICAL_WORD_FIRST_EN
    logic [LOGLINEOFFSET-1:0]   startWord;
`endif

    // ------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            beat    <= '0;
            cnt     <= '0;
            lineIdx <= '0;
            tagReg  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            startWord <= '0;
`endif
        end else begin
            state <= stateNxt;
            beat  <= beatNxt;
            cnt   <= cntNxt;
            if (state == IDLE && reqcyc) begin
                lineIdx <= reqIdx;
                tagReg  <= reqtag;
`ifdef CRITICAL_WORD_FIRST_EN
                startWord <= req[LOGLINEOFFSET+2:3];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNxt = state;
        beatNxt  = beat;
        cntNxt   = cnt;
        ackRaw   = 1'b0;
        storeWe  = 1'b0;

        unique case (state)
            IDLE: begin
                if (reqcyc) begin
                    ackRaw  = 1'b1;
                    beatNxt = '0;
                    if (reqtag[TAGWIDTH-1]) begin
                        stateNxt = LAT_WAIT;
                        cntNxt   = LATW'(LATENCY - 1);
                    end else begin
                        stateNxt = WR_BEATS;
                    end
                end
            end

            LAT_WAIT: begin
                if (cnt == '0) begin
                    stateNxt = RD_BEATS;
                    beatNxt  = '0;
                end else begin
                    cntNxt = cnt - 1'b1;
                end
            end

            RD_BEATS: begin
                if (respack) begin
                    // beat wraps back to 0 after the last one
                    beatNxt = beat + 1'b1;
                    if (&beat) begin
                        stateNxt = IDLE;
                    end
                end
            end

            WR_BEATS: begin
                if (reqcyc) begin
                    ackRaw  = 1'b1;
                    storeWe = 1'b1;
                    beatNxt = beat + 1'b1;
                    if (&beat) begin
                        stateNxt = WR_DONE;
                    end
                end
            end

            WR_DONE: begin
                stateNxt = IDLE;
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // The read port is addressed with the beat for the *next* cycle so that the
    // registered read data lines up with the beat being presented. While a beat
    // stalls, the same word is simply re-read, keeping resp stable.
`ifdef CRITICAL_WORD_FIRST_EN
    assign readWord = beatNxt + startWord;
`else
    assign readWord = beatNxt;
`endif

    line_store #(
        .WORDSIZE (WORDSIZE),
        .ADDRW    (ADDRW)
    ) u_store (
        .clk       (clk),
        .writeEn   (storeWe),
        .writeAddr ({lineIdx, beat}),
        .writeData (req),
        .readAddr  ({lineIdx, readWord}),
        .readData  (readData)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // reqack is combinational on reqcyc; masking with reset_n keeps it low
    // while reset is held even if the requester drives reqcyc.
    assign reqack   = ackRaw & reset_n;
    assign respcyc  = (state == RD_BEATS);
    assign resp     = respcyc ? readData : '0;
    assign resptag  = tagReg;
    assign writeack = (state == WR_DONE);
    assign dbgState = state;

endmodule

// File: tb/tb_line_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_line_fill_responder
// Directed bench for line_fill_responder with default parameters
// (64-bit words, 8 beats per line, 1024 lines, latency 4, 13-bit tags).
// Inputs are driven and outputs sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_line_fill_responder;
    import line_bus_pkg::*;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reqcyc = 1'b0;
    logic [63:0] req = '0;
    logic [12:0] reqtag = '0;
    logic        respack = 1'b0;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        writeack;
    resp_state_e dbgState;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_fill_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .reqcyc   (reqcyc),
        .req      (req),
        .reqtag   (reqtag),
        .reqack   (reqack),
        .respcyc  (respcyc),
        .resp     (resp),
        .resptag  (resptag),
        .respack  (respack),
        .writeack (writeack),
        .dbgState (dbgState)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write burst: address phase, 8 data beats base+0..base+7, optional idle
    // gap after beat gapAfter (8 = no gap). Entered on a falling edge in IDLE.
    task automatic doWrite(input logic [63:0] addr, input logic [12:0] tag,
                           input logic [63:0] base, input int gapAfter);
        reqcyc = 1'b1; req = addr; reqtag = tag; #1;
        check("wr_addr_ack", 64'(reqack), 64'd1);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            reqcyc = 1'b1; req = base + 64'(b); #1;
            check("wr_beat_ack", 64'(reqack), 64'd1);
            check("wr_no_early_writeack", 64'(writeack), 64'd0);
            @(negedge clk);
            if (b == gapAfter) begin
                reqcyc = 1'b0; #1;
                check("wr_gap_noack", 64'(reqack), 64'd0);
                @(negedge clk);
            end
        end
        reqcyc = 1'b0; #1;
        check("wr_done_pulse", 64'(writeack), 64'd1);
        @(negedge clk); #1;
        check("wr_ack_clear", 64'(writeack), 64'd0);
        check("wr_back_idle", 64'(dbgState), 64'(IDLE));
    endtask

    // Read burst: expects beat b = base + ((start + b) mod 8). Beat stallBeat
    // is held with respack low for stallN cycles. At beat abortBeat reset is
    // pulsed instead of completing (8 = no abort).
    task automatic doRead(input logic [63:0] addr, input logic [12:0] tag,
                          input logic [63:0] base, input int start,
                          input int stallBeat, input int stallN, input int abortBeat);
        int idle;
        logic [63:0] exp;
        reqcyc = 1'b1; req = addr; reqtag = tag; respack = 1'b0; #1;
        check("rd_addr_ack", 64'(reqack), 64'd1);
        @(negedge clk);
        // respack held high while no beat is offered must be ignored
        reqcyc = 1'b0; respack = 1'b1; #1;
        check("rd_lat_noack", 64'(reqack), 64'd0);
        idle = 0;
        while (respcyc !== 1'b1 && idle < 20) begin
            idle++;
            @(negedge clk); #1;
        end
        check("rd_latency", 64'(idle), 64'(LAT));
        for (int b = 0; b < 8; b++) begin
            exp = base + 64'((start + b) % 8);
            if (b == abortBeat) begin
                reset_n = 1'b0; #1;
                check("abort_respcyc", 64'(respcyc), 64'd0);
                check("abort_resp", resp, 64'd0);
                check("abort_resptag", 64'(resptag), 64'd0);
                check("abort_idle", 64'(dbgState), 64'(IDLE));
                respack = 1'b0;
                @(negedge clk);
                reset_n = 1'b1; #1;
                return;
            end
            if (b == stallBeat) begin
                for (int s = 0; s < stallN; s++) begin
                    respack = 1'b0; #1;
                    check("rd_stall_data", resp, exp);
                    check("rd_stall_valid", 64'(respcyc), 64'd1);
                    @(negedge clk);
                end
            end
            respack = 1'b1; #1;
            check("rd_beat_data", resp, exp);
            check("rd_beat_tag", 64'(resptag), 64'(tag));
            check("rd_beat_valid", 64'(respcyc), 64'd1);
            @(negedge clk);
        end
        respack = 1'b0; #1;
        check("rd_end_respcyc", 64'(respcyc), 64'd0);
        check("rd_end_idle", 64'(dbgState), 64'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with a request already pending: no acknowledge may appear
        reset_n = 1'b0; reqcyc = 1'b1; req = 64'h140; reqtag = 13'h1000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_reqack", 64'(reqack), 64'd0);
        check("rst_respcyc", 64'(respcyc), 64'd0);
        check("rst_writeack", 64'(writeack), 64'd0);
        check("rst_resp", resp, 64'd0);
        check("rst_resptag", 64'(resptag), 64'd0);
        check("rst_state", 64'(dbgState), 64'(IDLE));
        reqcyc = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // preload line 5 with 0x50..0x57
        doWrite(64'h140, 13'h0005, 64'h50, 8);
        // plain read of line 5
        doRead(64'h140, 13'h1003, 64'h50, 0, 8, 0, 8);
        // same read, beat 2 stalled for 3 cycles
        doRead(64'h140, 13'h1003, 64'h50, 0, 2, 3, 8);
        // write line 1 with a gap after beat 3, then read it back
        doWrite(64'h40, 13'h0007, 64'hA0, 3);
        doRead(64'h40, 13'h1007, 64'hA0, 0, 8, 0, 8);
        // line 5 untouched by the line 1 write
        doRead(64'h140, 13'h1011, 64'h50, 0, 8, 0, 8);
        // request at word 3 of line 5
`ifdef CRITICAL_WORD_FIRST_EN
        doRead(64'h158, 13'h1009, 64'h50, 3, 8, 0, 8);
`else
        doRead(64'h158, 13'h1009, 64'h50, 0, 8, 0, 8);
`endif
        // address above the store size aliases back to line 5
        doRead(64'h140 + (64'd1 << 16), 13'h100A, 64'h50, 0, 8, 0, 8);
        // reset during beat 4, then a normal read
        doRead(64'h140, 13'h1004, 64'h50, 0, 8, 0, 4);
        @(negedge clk);
        doRead(64'h140, 13'h1005, 64'h50, 0, 8, 0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
- Memory-side responder for the cache-arbiter line protocol. It sits on the arbiter side of a cache's downstream bus.
- Accepts line-aligned read and write requests from a cache controller.
- Reads: returns a full cache line as 2^LOGLINEOFFSET beats.
- Writes: absorbs 2^LOGLINEOFFSET data beats, then pulses writeack.
- Backed by an internal line store with programmable access latency; used as the memory model for L1 bring-up and as a refill target.

Parameters:
- WORDSIZE, 64, bits per beat and per address.
- LOGLINEOFFSET, 3, log2 of beats (words) per line; 8 beats = 64-byte line.
- LOGDEPTH, 10, log2 of lines held in the internal store.
- LATENCY, 4, idle cycles between reqack and the first read beat; minimum 1.
- TAGWIDTH, 13, request/response tag width; bit TAGWIDTH-1 is the READ flag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqcyc  in  1  request valid (address phase, or data beat during a write).
- req  in  WORDSIZE  byte address in address phase; write data during write beats.
- reqtag  in  TAGWIDTH  bit 12 = 1 read, 0 write; bits [11:0] opaque id.
- reqack  out  1  one-cycle acknowledge of the address phase or of a write beat.
- respcyc  out  1  read beat valid.
- resp  out  WORDSIZE  read beat data.
- resptag  out  TAGWIDTH  copy of the captured reqtag.
- respack  in  1  requester accepts the current read beat.
- writeack  out  1  one-cycle pulse after the final write beat is stored.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Outputs: reqack, respcyc, writeack = 0; resp, resptag = 0.
  - Internal: FSM goes to IDLE, beat counter and latency counter cleared.
  - Line store contents are not cleared.
  - Reset mid-transaction aborts it. Partially written lines keep only the beats already stored.
- Address decode: line index = req[LOGLINEOFFSET+3 +: LOGDEPTH]. Higher address bits are ignored, so the index aliases modulo the store size. Byte offset bits [2:0] are ignored.
- IDLE:
  - On reqcyc=1: capture the index, the start word req[LOGLINEOFFSET+2:3] and reqtag; assert reqack for exactly one cycle.
  - Next state: read (reqtag[12]=1) goes to LAT_WAIT with counter=LATENCY-1; write goes to WR_BEATS with beat=0.
- LAT_WAIT: decrement the counter each cycle; at 0, go to RD_BEATS with beat=0.
- RD_BEATS:
  - Drive respcyc=1, resp = word[beat] of the captured line, resptag = captured tag.
  - The beat advances only on a cycle where respcyc && respack; otherwise data is held stable.
  - After the last beat (beat = 2^LOGLINEOFFSET-1) is accepted: respcyc drops the next cycle and the FSM returns to IDLE.
  - respack while respcyc=0 is ignored.
- WR_BEATS:
  - Each cycle with reqcyc=1: write req into word[beat] of the captured line, pulse reqack, increment beat.
  - Cycles with reqcyc=0 are stalls with no effect.
  - After the last beat: go to WR_DONE.
- WR_DONE: pulse writeack for one cycle, return to IDLE.
- reqack never asserts in two consecutive cycles for the same transfer. Back-to-back write beats get reqack on each accepted beat.
- New requests are not accepted outside IDLE. reqcyc held high across the return to IDLE is taken as a new request one cycle after the transaction ends.
- Read-after-write to the same line returns the new data; the write completes before IDLE is re-entered.
- Line-store write and read use separate ports. A same-cycle read of a word being written is not possible by construction.

Optional Feature:
- CRITICAL_WORD_FIRST_EN defined: read beat n returns word[(start+n) mod 2^LOGLINEOFFSET], and resptag is unchanged. Write beats still fill from word 0.
- Undefined: read beats always run word 0..7 and the start word is ignored.

Decomposition:
- Package line_bus_pkg:
  - resp_state_e enum (IDLE, LAT_WAIT, RD_BEATS, WR_BEATS, WR_DONE).
  - READ_BIT constant = 12.
  - BEATS constant = 1<<LOGLINEOFFSET.
- One sub-module, line_store: a two-port word-addressed array {LOGDEPTH, LOGLINEOFFSET}→WORDSIZE with a registered read.
- The responder FSM wraps line_store.

Test Plan:
- Preload line 5 with words 0x50..0x57; read req=0x140, tag=0x1003 → reqack 1 cycle; first respcyc 4 cycles later; beats 0x50..0x57; resptag=0x1003 on every beat.
- Same read with respack held low 3 cycles on beat 2 → resp stays 0x52 for the stall, then the sequence continues unchanged.
- Write req=0x40, tag=0x0007, beats 0xA0..0xA7 with one reqcyc gap after beat 3 → 8 reqack pulses, writeack 1 cycle after the 8th; a subsequent read of 0x40 returns 0xA0..0xA7.
- With CRITICAL_WORD_FIRST_EN, read req=0x158 (word 3 of line 5) → beats 0x53,0x54..0x57,0x50,0x51,0x52.
- Read req=0x140 + (1<<(LOGDEPTH+6)) → aliases to line 5 and returns 0x50..0x57.
- Assert reset_n=0 during read beat 4 → respcyc=0 immediately; FSM in IDLE; the next read completes normally.
